// File: rtl/axis_route_pkg.sv
// Shared types and constants for the axis_route_sel routing stage.
package axis_route_pkg;

  typedef enum logic {
    SOP    = 1'b0,
    IN_PKT = 1'b1
  } route_state_e;

  localparam int CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage

// File: rtl/axis_route_sel_if.sv
// AXI4-Stream bundle used on both sides of the routing stage.
interface axis_route_sel_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TUSER_WIDTH = 16
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_route_lookup.sv
// Combinational routing-key compare: lowest matching channel index wins,
// unmatched keys fall back to DEFAULT_CH.
module axis_route_lookup #(
  parameter int                        NUM_CH     = 4,
  parameter int                        KEY_WIDTH  = 8,
  parameter logic [NUM_CH*KEY_WIDTH-1:0] ROUTE_KEYS = {8'h30, 8'h20, 8'h10, 8'h00},
  parameter int                        DEFAULT_CH = 0,
  localparam int                       SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 unmatched_o
);

  // Scanning from the top down lets the lowest duplicate overwrite last.
  always_comb begin
    sel_o       = SEL_WIDTH'(DEFAULT_CH);
    unmatched_o = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (key_i == ROUTE_KEYS[i*KEY_WIDTH +: KEY_WIDTH]) begin
        sel_o       = SEL_WIDTH'(i);
        unmatched_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_route_sel.sv
// Output register slice that tags each beat with a per-packet channel select.
// Optional macro AXIS_ROUTE_DROP_EN: discard unmatched packets instead of routing to DEFAULT_CH.
module axis_route_sel
  import axis_route_pkg::*;
#(
  parameter int                          NUM_CH      = 4,
  parameter int                          TDATA_WIDTH = 512,
  parameter int                          TID_WIDTH   = 8,
  parameter int                          TDEST_WIDTH = 8,
  parameter int                          TUSER_WIDTH = 16,
  parameter int                          KEY_LSB     = 0,
  parameter int                          KEY_WIDTH   = 8,
  parameter logic [NUM_CH*KEY_WIDTH-1:0] ROUTE_KEYS  = {8'h30, 8'h20, 8'h10, 8'h00},
  parameter int                          DEFAULT_CH  = 0,
  localparam int                         SEL_WIDTH   = $clog2(NUM_CH),
  localparam int                         TKEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_route_sel_if.slave       s_axis,
  axis_route_sel_if.master      m_axis,
  output logic [SEL_WIDTH-1:0]  m_sel,
  output logic [CNT_WIDTH-1:0]  unmatched_cnt
);

  route_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0]   held_q, held_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [TKEEP_WIDTH-1:0] tkeep_q;
  logic                   tlast_q;
  logic [TID_WIDTH-1:0]   tid_q;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
`ifdef AXIS_ROUTE_DROP_EN
  logic                   drop_q, drop_d;
`endif

  logic                   accept;
  logic                   load;
  logic [SEL_WIDTH-1:0]   lk_sel;
  logic                   lk_unmatched;

  axis_route_lookup #(
    .NUM_CH     (NUM_CH),
    .KEY_WIDTH  (KEY_WIDTH),
    .ROUTE_KEYS (ROUTE_KEYS),
    .DEFAULT_CH (DEFAULT_CH)
  ) u_lookup (
    .key_i       (s_axis.tuser[KEY_LSB +: KEY_WIDTH]),
    .sel_o       (lk_sel),
    .unmatched_o (lk_unmatched)
  );

  assign s_axis.tready = !valid_q || m_axis.tready;
  assign accept        = s_axis.tvalid && s_axis.tready;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef AXIS_ROUTE_DROP_EN
    drop_d  = drop_q;
`endif
    if (accept) begin
      if (state_q == SOP) begin
        sel_d   = lk_sel;
        held_d  = lk_sel;
        state_d = s_axis.tlast ? SOP : IN_PKT;
        if (lk_unmatched && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef AXIS_ROUTE_DROP_EN
        drop_d = lk_unmatched;
        load   = !lk_unmatched;
`else
        load   = 1'b1;
`endif
      end else begin
        sel_d = held_q;
        if (s_axis.tlast) begin
          state_d = SOP;
        end
`ifdef AXIS_ROUTE_DROP_EN
        load = !drop_q;
`else
        load = 1'b1;
`endif
      end
    end
    // A dropped beat still frees the slot if the consumer took the old one.
    if (load) begin
      valid_d = 1'b1;
    end else if (m_axis.tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SOP;
      held_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
      tid_q   <= '0;
      tdest_q <= '0;
      tuser_q <= '0;
`ifdef AXIS_ROUTE_DROP_EN
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
`ifdef AXIS_ROUTE_DROP_EN
      drop_q  <= drop_d;
`endif
      if (load) begin
        sel_q   <= sel_d;
        tdata_q <= s_axis.tdata;
        tkeep_q <= s_axis.tkeep;
        tlast_q <= s_axis.tlast;
        tid_q   <= s_axis.tid;
        tdest_q <= s_axis.tdest;
        tuser_q <= s_axis.tuser;
      end
    end
  end

  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tid    = tid_q;
  assign m_axis.tdest  = tdest_q;
  assign m_axis.tuser  = tuser_q;
  assign m_sel         = sel_q;
  assign unmatched_cnt = cnt_q;

endmodule
